// File: rtl/zz_seq_pkg.sv
// Shared types and constants for the zigzag block sequencer: FSM states,
// last scan index per block size, and the incoming token layout.
package zz_seq_pkg;

    localparam int LAST_8     = 63;
    localparam int LAST_16    = 255;
    localparam int TOK_RUN_W  = 8;
    localparam int TOK_COEF_W = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ACCEPT,
        ST_ZERO_RUN,
        ST_LEVEL,
        ST_FILL,
        ST_BLK_DONE,
        ST_WAIT_BANK
    } seq_state_t;

    typedef struct packed {
        logic [TOK_RUN_W-1:0]         run;
        logic signed [TOK_COEF_W-1:0] level;
        logic                         eob;
    } token_t;

endpackage

// File: rtl/zz_scan_gen.sv
// Zigzag scan position generator for 8x8 or 16x16 blocks; advances one
// position per step and flags the final position of the block.
module zz_scan_gen
    import zz_seq_pkg::*;
(
    input  logic       Clock_50,
    input  logic       Resetn,
    input  logic       clear,
    input  logic       step,
    input  logic       mode,
    output logic [3:0] row,
    output logic [3:0] col,
    output logic       last
);

    logic [3:0] max_rc;
    logic       up_right;

    assign max_rc   = mode ? 4'd15 : 4'd7;
    // Even anti-diagonals run toward the top-right, odd ones toward the bottom-left.
    assign up_right = ~(row[0] ^ col[0]);

    always_comb begin
        if (mode)
            last = ({row, col} == 8'(LAST_16));
        else
            last = ({row[2:0], col[2:0]} == 6'(LAST_8));
    end

    always_ff @(posedge Clock_50 or negedge Resetn) begin
        if (!Resetn) begin
            row <= 4'd0;
            col <= 4'd0;
        end else if (clear) begin
            row <= 4'd0;
            col <= 4'd0;
        end else if (step) begin
            if (up_right) begin
                if (col == max_rc) begin
                    row <= row + 4'd1;
                end else if (row == 4'd0) begin
                    col <= col + 4'd1;
                end else begin
                    row <= row - 4'd1;
                    col <= col + 4'd1;
                end
            end else begin
                if (row == max_rc) begin
                    col <= col + 4'd1;
                end else if (col == 4'd0) begin
                    row <= row + 4'd1;
                end else begin
                    row <= row + 4'd1;
                    col <= col - 4'd1;
                end
            end
        end
    end

endmodule

// File: rtl/zz_block_sequencer.sv
// Expands run-length coefficient tokens into fully written zigzag blocks
// in a two-bank RAM and hands filled banks to the consumer in order.
module zz_block_sequencer
    import zz_seq_pkg::*;
#(
    parameter int COEF_W = 16,
    parameter int RUN_W  = 8
) (
    input  logic                     Clock_50,
    input  logic                     Resetn,
    input  logic                     mode,
    input  logic                     tok_valid,
    output logic                     tok_ready,
    input  logic [RUN_W-1:0]         tok_run,
    input  logic signed [COEF_W-1:0] tok_level,
    input  logic                     tok_eob,
    output logic                     wr_en,
    output logic [8:0]               wr_addr,
    output logic signed [COEF_W-1:0] wr_data,
    output logic                     blk_valid,
    output logic                     blk_bank,
    input  logic                     blk_ack,
    output logic                     err_overrun
);

    seq_state_t state_q, state_d;

    token_t                   tok_in;
    logic                     tok_fire;
    logic [TOK_RUN_W-1:0]     run_cnt;
    logic signed [COEF_W-1:0] level_q;
    logic                     mode_q;
    logic                     at_start;

    logic [1:0] full_q, full_d;
    logic       wbank_q;
    logic       rptr_q;
    logic       ack_ok;

    logic       wr_now, wr_level, scan_step, scan_clear, set_full, overrun_now;
    logic [3:0] scan_row, scan_col;
    logic       scan_last;
    logic [7:0] scan_pos;

    assign tok_in   = '{run: TOK_RUN_W'(tok_run), level: TOK_COEF_W'(tok_level), eob: tok_eob};
    assign tok_fire = tok_valid & tok_ready;
    assign ack_ok   = blk_ack & (|full_q);

    assign blk_valid = |full_q;
    assign blk_bank  = rptr_q;

    zz_scan_gen u_scan (
        .Clock_50 (Clock_50),
        .Resetn   (Resetn),
        .clear    (scan_clear),
        .step     (scan_step),
        .mode     (mode_q),
        .row      (scan_row),
        .col      (scan_col),
        .last     (scan_last)
    );

    assign scan_pos = mode_q ? {scan_row, scan_col} : {2'b00, scan_row[2:0], scan_col[2:0]};

    // ---- state register ----
    always_ff @(posedge Clock_50 or negedge Resetn) begin
        if (!Resetn)
            state_q <= ST_IDLE;
        else
            state_q <= state_d;
    end

    // ---- next-state logic ----
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:      state_d = ST_ACCEPT;
            ST_ACCEPT: begin
                if (tok_fire) begin
                    if (tok_in.eob)
                        state_d = ST_FILL;
                    else if (tok_in.run != '0)
                        state_d = ST_ZERO_RUN;
                    else
                        state_d = ST_LEVEL;
                end
            end
            // Reaching the last position with zeros still pending drops the level.
            ST_ZERO_RUN: begin
                if (scan_last)
                    state_d = ST_BLK_DONE;
                else if (run_cnt == TOK_RUN_W'(1))
                    state_d = ST_LEVEL;
            end
            ST_LEVEL:     state_d = scan_last ? ST_BLK_DONE : ST_ACCEPT;
            ST_FILL:      if (scan_last) state_d = ST_BLK_DONE;
            ST_BLK_DONE:  state_d = full_d[~wbank_q] ? ST_WAIT_BANK : ST_ACCEPT;
            ST_WAIT_BANK: if (!full_d[wbank_q]) state_d = ST_ACCEPT;
            default:      state_d = ST_IDLE;
        endcase
    end

    // ---- per-state actions ----
    always_comb begin
        wr_now      = 1'b0;
        wr_level    = 1'b0;
        set_full    = 1'b0;
        scan_clear  = 1'b0;
        overrun_now = 1'b0;
        case (state_q)
            ST_ZERO_RUN: begin
                wr_now      = 1'b1;
                overrun_now = scan_last;
            end
            ST_LEVEL: begin
                wr_now   = 1'b1;
                wr_level = 1'b1;
            end
            ST_FILL:     wr_now = 1'b1;
            ST_BLK_DONE: begin
                set_full   = 1'b1;
                scan_clear = 1'b1;
            end
            default: ;
        endcase
        scan_step = wr_now & ~scan_last;
    end

    // ---- token capture and run counter ----
    always_ff @(posedge Clock_50 or negedge Resetn) begin
        if (!Resetn) begin
            run_cnt  <= '0;
            level_q  <= '0;
            mode_q   <= 1'b0;
            at_start <= 1'b1;
        end else begin
            if (tok_fire) begin
                run_cnt  <= tok_in.run;
                level_q  <= COEF_W'(tok_in.level);
                at_start <= 1'b0;
                if (at_start)
                    mode_q <= mode;
            end else if (state_q == ST_ZERO_RUN) begin
                run_cnt <= run_cnt - TOK_RUN_W'(1);
            end
            if (set_full)
                at_start <= 1'b1;
        end
    end

    // ---- bank bookkeeping ----
    always_comb begin
        full_d = full_q;
        if (ack_ok)
            full_d[rptr_q] = 1'b0;
        if (set_full)
            full_d[wbank_q] = 1'b1;
    end

    always_ff @(posedge Clock_50 or negedge Resetn) begin
        if (!Resetn) begin
            full_q  <= 2'b00;
            wbank_q <= 1'b0;
            rptr_q  <= 1'b0;
        end else begin
            full_q <= full_d;
            if (set_full)
                wbank_q <= ~wbank_q;
            if (ack_ok)
                rptr_q <= ~rptr_q;
        end
    end

    // ---- registered outputs ----
    always_ff @(posedge Clock_50 or negedge Resetn) begin
        if (!Resetn) begin
            tok_ready   <= 1'b0;
            wr_en       <= 1'b0;
            wr_addr     <= '0;
            wr_data     <= '0;
            err_overrun <= 1'b0;
        end else begin
            tok_ready <= (state_d == ST_ACCEPT);
            wr_en     <= wr_now;
            wr_addr   <= {wbank_q, scan_pos};
            wr_data   <= wr_level ? level_q : '0;
            if (overrun_now)
                err_overrun <= 1'b1;
        end
    end

endmodule

// File: tb/tb_zz_block_sequencer.sv
// Scoreboard bench for zz_block_sequencer: directed token streams, an
// independent zigzag model feeding an expected-write queue, and a monitor.
module tb_zz_block_sequencer;

    localparam int COEF_W = 16;
    localparam int RUN_W  = 8;

    logic                     Clock_50 = 1'b0;
    logic                     Resetn = 1'b0;
    logic                     mode = 1'b0;
    logic                     tok_valid = 1'b0;
    logic [RUN_W-1:0]         tok_run = '0;
    logic signed [COEF_W-1:0] tok_level = '0;
    logic                     tok_eob = 1'b0;
    logic                     blk_ack = 1'b0;
    logic                     tok_ready, wr_en, blk_valid, blk_bank, err_overrun;
    logic [8:0]               wr_addr;
    logic signed [COEF_W-1:0] wr_data;

    zz_block_sequencer #(.COEF_W(COEF_W), .RUN_W(RUN_W)) dut (
        .Clock_50    (Clock_50),
        .Resetn      (Resetn),
        .mode        (mode),
        .tok_valid   (tok_valid),
        .tok_ready   (tok_ready),
        .tok_run     (tok_run),
        .tok_level   (tok_level),
        .tok_eob     (tok_eob),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .blk_valid   (blk_valid),
        .blk_bank    (blk_bank),
        .blk_ack     (blk_ack),
        .err_overrun (err_overrun)
    );

    always #5 Clock_50 = ~Clock_50;

    typedef struct {
        logic [8:0]  addr;
        logic [15:0] data;
        bit          last;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   zr8[64], zc8[64], zr16[256], zc16[256];
    int   m_idx = 0, m_wb = 0;
    bit   m_mode = 1'b0;
    bit   ignore_wr = 1'b0, rise_chk = 1'b0, rise_pend = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Zigzag order by anti-diagonal: odd diagonals walk row upward from 0, even ones downward.
    task automatic build(input int n);
        int k = 0;
        for (int s = 0; s <= 2 * n - 2; s++) begin
            for (int i = 0; i < n; i++) begin
                int r, c;
                r = (s % 2 == 1) ? i : n - 1 - i;
                c = s - r;
                if (c >= 0 && c < n) begin
                    if (n == 8) begin zr8[k] = r; zc8[k] = c; end
                    else begin zr16[k] = r; zc16[k] = c; end
                    k++;
                end
            end
        end
    endtask

    task automatic push(input int data, input bit last);
        exp_t e;
        int r, c;
        r = m_mode ? zr16[m_idx] : zr8[m_idx];
        c = m_mode ? zc16[m_idx] : zc8[m_idx];
        e.addr = 9'(m_wb * 256 + (m_mode ? r * 16 + c : r * 8 + c));
        e.data = 16'(data);
        e.last = last;
        q.push_back(e);
    endtask

    task automatic model_tok(input int run, input int lvl, input bit eob);
        int last_i;
        if (m_idx == 0) m_mode = mode;
        last_i = m_mode ? 255 : 63;
        if (eob) begin
            while (m_idx < last_i) begin push(0, 1'b0); m_idx++; end
            push(0, 1'b1);
            m_wb ^= 1; m_idx = 0;
            return;
        end
        for (int k = 0; k < run; k++) begin
            push(0, m_idx == last_i);
            if (m_idx == last_i) begin m_wb ^= 1; m_idx = 0; return; end
            m_idx++;
        end
        push(lvl, m_idx == last_i);
        if (m_idx == last_i) begin m_wb ^= 1; m_idx = 0; end
        else m_idx++;
    endtask

    task automatic send(input int run, input int lvl, input bit eob, input bit model);
        int n = 0;
        if (model) model_tok(run, lvl, eob);
        @(negedge Clock_50);
        tok_valid = 1'b1;
        tok_run   = RUN_W'(run);
        tok_level = COEF_W'(lvl);
        tok_eob   = eob;
        while (!tok_ready && n < 3000) begin @(negedge Clock_50); n++; end
        if (n >= 3000) begin
            check("send_timeout", {31'b0, tok_ready}, 32'd1);
            tok_valid = 1'b0;
            return;
        end
        @(posedge Clock_50);
        #1 tok_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (q.size() != 0 && n < 3000) begin @(negedge Clock_50); n++; end
        if (n >= 3000) check("drain_timeout", q.size(), 32'd0);
        repeat (3) @(negedge Clock_50);
    endtask

    task automatic ack();
        @(negedge Clock_50); blk_ack = 1'b1;
        @(negedge Clock_50); blk_ack = 1'b0;
    endtask

    task automatic chk_reset(input string tag);
        check({tag, "_tok_ready"},   {31'b0, tok_ready},   32'd0);
        check({tag, "_wr_en"},       {31'b0, wr_en},       32'd0);
        check({tag, "_wr_addr"},     {23'b0, wr_addr},     32'd0);
        check({tag, "_wr_data"},     {16'b0, wr_data},     32'd0);
        check({tag, "_blk_valid"},   {31'b0, blk_valid},   32'd0);
        check({tag, "_blk_bank"},    {31'b0, blk_bank},    32'd0);
        check({tag, "_err_overrun"}, {31'b0, err_overrun}, 32'd0);
    endtask

    always @(negedge Clock_50) begin
        if (rise_pend) begin
            check("blk_valid_rise", {31'b0, blk_valid}, 32'd1);
            rise_pend = 1'b0;
        end
        if (wr_en && !ignore_wr) begin
            if (q.size() == 0) begin
                check("unexpected_write", {23'b0, wr_addr}, 32'hFFFF_FFFF);
            end else begin
                mon_e = q.pop_front();
                check("wr_addr", {23'b0, wr_addr}, {23'b0, mon_e.addr});
                check("wr_data", {16'b0, wr_data}, {16'b0, mon_e.data});
                if (mon_e.last) begin
                    if (rise_chk) check("blk_valid_early", {31'b0, blk_valid}, 32'd0);
                    rise_pend = 1'b1;
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        build(8);
        build(16);
        #12;
        chk_reset("rst0");
        @(negedge Clock_50) Resetn = 1'b1;
        repeat (2) @(negedge Clock_50);
        check("ready_after_reset", {31'b0, tok_ready}, 32'd1);

        // 8x8 sparse block into bank 0
        rise_chk = 1'b1;
        send(0, 5, 0, 1);
        send(2, -3, 0, 1);
        send(0, 0, 1, 1);
        drain();
        check("t1_blk_valid", {31'b0, blk_valid}, 32'd1);
        check("t1_blk_bank",  {31'b0, blk_bank},  32'd0);
        check("t1_err",       {31'b0, err_overrun}, 32'd0);
        ack();
        @(negedge Clock_50);
        check("t1_released", {31'b0, blk_valid}, 32'd0);

        // all-zero block from a bare EOB
        send(0, 0, 1, 1);
        drain();
        check("t2_blk_bank", {31'b0, blk_bank}, 32'd1);
        ack();

        // overrun: run past the last position
        send(70, 99, 0, 1);
        drain();
        check("t3_err",       {31'b0, err_overrun}, 32'd1);
        check("t3_blk_valid", {31'b0, blk_valid},   32'd1);
        check("t3_blk_bank",  {31'b0, blk_bank},    32'd0);

        // both banks fill, third block stalls until an ack
        rise_chk = 1'b0;
        send(1, 11, 0, 1);
        send(0, 0, 1, 1);
        drain();
        check("t4_blk_bank_oldest", {31'b0, blk_bank}, 32'd0);
        fork
            begin
                send(0, -2, 0, 1);
                send(0, 0, 1, 1);
            end
        join_none
        repeat (5) begin
            @(negedge Clock_50);
            check("t4_stall_ready", {31'b0, tok_ready}, 32'd0);
            check("t4_stall_wr",    {31'b0, wr_en},     32'd0);
        end
        @(negedge Clock_50) blk_ack = 1'b1;
        @(negedge Clock_50);
        check("t4_ready_after_ack", {31'b0, tok_ready}, 32'd1);
        check("t4_bank_after_ack",  {31'b0, blk_bank},  32'd1);
        blk_ack = 1'b0;
        drain();
        wait fork;
        drain();
        check("t4_blk_valid", {31'b0, blk_valid},   32'd1);
        check("t4_err_sticky", {31'b0, err_overrun}, 32'd1);
        ack();
        ack();
        @(negedge Clock_50);
        check("t4_all_released", {31'b0, blk_valid}, 32'd0);
        ack();
        @(negedge Clock_50);
        check("t4_spurious_ack_bank", {31'b0, blk_bank}, 32'd1);

        // 16x16 dense block, mode toggled mid-block
        rise_chk = 1'b1;
        mode = 1'b1;
        for (int i = 0; i < 256; i++) begin
            if (i == 100) mode = 1'b0;
            send(0, (i % 2 == 1) ? -(i * 7) : i * 5 + 1, 0, 1);
        end
        drain();
        check("t5_blk_valid", {31'b0, blk_valid}, 32'd1);
        check("t5_blk_bank",  {31'b0, blk_bank},  32'd1);

        // reset in the middle of a zero run
        mode = 1'b0;
        ignore_wr = 1'b1;
        send(40, 3, 0, 0);
        repeat (6) @(negedge Clock_50);
        #2 Resetn = 1'b0;
        #1 chk_reset("rst_mid");
        q.delete();
        m_idx = 0; m_wb = 0; m_mode = 1'b0;
        @(negedge Clock_50) Resetn = 1'b1;
        ignore_wr = 1'b0;
        repeat (2) @(negedge Clock_50);
        send(0, 7, 0, 1);
        send(0, 0, 1, 1);
        drain();
        check("t6_blk_bank",  {31'b0, blk_bank},    32'd0);
        check("t6_blk_valid", {31'b0, blk_valid},   32'd1);
        check("t6_err",       {31'b0, err_overrun}, 32'd0);
        check("queue_empty",  q.size(),             32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
